// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin sharing of a fixed-latency single-port memory
//            between the fetch (IF) and data (DM) pipeline ports.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY_IF = 2'd1;
    localparam logic [1:0] c_BUSY_DM = 2'd2;
    localparam logic [3:0] c_LAT     = 4'(MEM_LAT);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_last_grant;
    logic              r_is_write;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_if_ready;
    logic              r_dm_ready;
    logic [15:0]       r_conflict_cnt;

    logic w_pend_if;
    logic w_pend_dm;
    logic w_idle;
    logic w_grant_if;
    logic w_grant_dm;
    logic w_done;
    logic w_conflict;

    // A port whose ready pulse is high has had its request consumed this cycle.
    assign w_pend_if  = if_req & ~r_if_ready;
    assign w_pend_dm  = (dm_read | dm_write) & ~r_dm_ready;
    assign w_idle     = (r_state == c_IDLE);
    assign w_grant_dm = w_idle & ~rst & w_pend_dm & (~w_pend_if | ~r_last_grant);
    assign w_grant_if = w_idle & ~rst & w_pend_if & ~w_grant_dm;
    assign w_done     = ~w_idle & (r_cnt == 4'd1);
    assign w_conflict = (w_idle & w_pend_if & w_pend_dm)
                      | ((r_state == c_BUSY_IF) & w_pend_dm)
                      | ((r_state == c_BUSY_DM) & w_pend_if);

    assign mem_en    = w_grant_if | w_grant_dm;
    assign mem_we    = w_grant_dm & dm_write;
    assign mem_addr  = w_grant_dm ? dm_addr : (w_grant_if ? if_addr : '0);
    assign mem_wdata = w_grant_dm ? dm_wdata : '0;

    assign if_rdata     = r_if_rdata;
    assign dm_rdata     = r_dm_rdata;
    assign if_ready     = r_if_ready;
    assign dm_ready     = r_dm_ready;
    assign if_stall     = if_req & ~r_if_ready;
    assign dm_stall     = (dm_read | dm_write) & ~r_dm_ready;
    assign conflict_cnt = r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_cnt          <= 4'd0;
            r_last_grant   <= 1'b0;
            r_is_write     <= 1'b0;
            r_if_rdata     <= '0;
            r_dm_rdata     <= '0;
            r_if_ready     <= 1'b0;
            r_dm_ready     <= 1'b0;
            r_conflict_cnt <= 16'd0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_grant_dm) begin
                        r_state      <= c_BUSY_DM;
                        r_cnt        <= c_LAT;
                        r_last_grant <= 1'b1;
                        r_is_write   <= dm_write;
                    end else if (w_grant_if) begin
                        r_state      <= c_BUSY_IF;
                        r_cnt        <= c_LAT;
                        r_last_grant <= 1'b0;
                        r_is_write   <= 1'b0;
                    end
                end
                c_BUSY_IF: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_done) begin
                        r_if_rdata <= mem_rdata;
                        r_if_ready <= 1'b1;
                        r_state    <= c_IDLE;
                    end
                end
                c_BUSY_DM: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_done) begin
                        // Stores complete with a pulse but keep the last load data.
                        if (!r_is_write) begin
                            r_dm_rdata <= mem_rdata;
                        end
                        r_dm_ready <= 1'b1;
                        r_state    <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter with a behavioural memory.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TB_LAT = 2;

    typedef struct {
        bit          dm;
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_read, dm_write;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, if_stall, dm_ready, dm_stall, mem_en, mem_we;
    logic [15:0] conflict_cnt;

    logic        l1_if_req, l1_dm_read, l1_dm_write;
    logic [31:0] l1_if_addr, l1_dm_addr, l1_dm_wdata, l1_mem_rdata;
    logic [31:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata;
    logic        l1_if_ready, l1_if_stall, l1_dm_ready, l1_dm_stall, l1_mem_en, l1_mem_we;
    logic [15:0] l1_conflict_cnt;

    int          cyc = 0;
    int          base = 0;
    int          compared = 0;
    int          mismatched = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mon_obs;
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] sched [int];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(TB_LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .dm_stall(dm_stall), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata),
        .if_ready(l1_if_ready), .if_stall(l1_if_stall),
        .dm_read(l1_dm_read), .dm_write(l1_dm_write), .dm_addr(l1_dm_addr),
        .dm_wdata(l1_dm_wdata), .dm_rdata(l1_dm_rdata), .dm_ready(l1_dm_ready),
        .dm_stall(l1_dm_stall), .mem_en(l1_mem_en), .mem_we(l1_mem_we),
        .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata),
        .conflict_cnt(l1_conflict_cnt)
    );

    // Behavioural memory plus completion scoreboard for the MEM_LAT=2 instance.
    always @(negedge clk) begin
        if (!rst && mem_en === 1'b1) begin
            if (mem_we) mem_model[mem_addr] = mem_wdata;
            else sched[cyc + TB_LAT] = mem_model.exists(mem_addr) ? mem_model[mem_addr] : {mem_addr[15:0], 16'hA5A5};
        end
        if (if_ready === 1'b1 || dm_ready === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_ready: got if_ready=%b dm_ready=%b at cycle %0d, required none", if_ready, dm_ready, cyc - base);
            end else begin
                mon_e   = sb.pop_front();
                mon_obs = mon_e.dm ? dm_rdata : if_rdata;
                if (dm_ready !== mon_e.dm || if_ready !== !mon_e.dm || cyc != mon_e.cyc || mon_obs !== mon_e.data) begin
                    mismatched++;
                    $display("FAIL completion: got dm=%b if=%b cycle %0d data %h, required dm=%b cycle %0d data %h",
                             dm_ready, if_ready, cyc - base, mon_obs, mon_e.dm, mon_e.cyc - base, mon_e.data);
                end
            end
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
        cyc++;
        mem_rdata = sched.exists(cyc) ? sched[cyc] : 32'hBAD0_BAD0;
    endtask

    task automatic do_reset;
        rst = 1'b1; if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
        next_cycle;
        next_cycle;
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic settle;
        if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
        next_cycle;
        next_cycle;
        base = cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h100;
        dm_read = 1'b0; dm_write = 1'b0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        next_cycle;
        @(negedge clk);
        compared++; if (mem_en !== 1'b0) begin mismatched++; $display("FAIL rst_mem_en: got %b required 0", mem_en); end
        compared++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ready: got %b%b required 00", if_ready, dm_ready); end
        compared++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin mismatched++; $display("FAIL rst_rdata: got %h %h required 0", if_rdata, dm_rdata); end
        compared++; if (conflict_cnt !== 16'h0) begin mismatched++; $display("FAIL rst_conflict: got %h required 0", conflict_cnt); end
        compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
        do_reset;
    endtask

    task automatic test_if_only;
        do_reset;
        mem_model[32'h100] = 32'h2402000A;
        sb.push_back('{1'b0, base + 4, 32'h2402000A});
        for (int t = 1; t <= 6; t++) begin
            next_cycle;
            if_req = (t <= 4); if_addr = 32'h100;
            @(negedge clk);
            compared++; if (mem_en !== (t == 1)) begin mismatched++; $display("FAIL if_only_mem_en t%0d: got %b required %b", t, mem_en, t == 1); end
            compared++; if (if_stall !== (t <= 3)) begin mismatched++; $display("FAIL if_only_stall t%0d: got %b required %b", t, if_stall, t <= 3); end
            if (t == 1) begin
                compared++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin mismatched++; $display("FAIL if_only_issue: got addr %h we %b required 100 0", mem_addr, mem_we); end
            end
        end
        compared++; if (if_rdata !== 32'h2402000A) begin mismatched++; $display("FAIL if_only_hold: got %h required 2402000a", if_rdata); end
        compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL if_only_missing: got %0d outstanding required 0", sb.size()); end
    endtask

    task automatic test_tie;
        do_reset;
        mem_model[32'h40]  = 32'h11112222;
        mem_model[32'h104] = 32'h33334444;
        sb.push_back('{1'b1, base + 4, 32'h11112222});
        sb.push_back('{1'b0, base + 7, 32'h33334444});
        for (int t = 1; t <= 8; t++) begin
            next_cycle;
            if_req = (t <= 7); if_addr = 32'h104; dm_read = (t <= 4); dm_addr = 32'h40;
            @(negedge clk);
            compared++; if (mem_en !== (t == 1 || t == 4)) begin mismatched++; $display("FAIL tie_mem_en t%0d: got %b required %b", t, mem_en, t == 1 || t == 4); end
            if (t == 1 || t == 4) begin
                compared++; if (mem_addr !== ((t == 1) ? 32'h40 : 32'h104)) begin mismatched++; $display("FAIL tie_mem_addr t%0d: got %h", t, mem_addr); end
            end
        end
        compared++; if (conflict_cnt !== 16'd3) begin mismatched++; $display("FAIL tie_conflict: got %0d required 3", conflict_cnt); end
        compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL tie_missing: got %0d outstanding required 0", sb.size()); end
    endtask

    task automatic test_back_to_back;
        do_reset;
        sb.push_back('{1'b1, base + 4,  32'h11112222});
        sb.push_back('{1'b0, base + 7,  32'h33334444});
        sb.push_back('{1'b1, base + 10, 32'h11112222});
        sb.push_back('{1'b0, base + 13, 32'h33334444});
        for (int t = 1; t <= 14; t++) begin
            next_cycle;
            if_req = (t <= 12); if_addr = 32'h104; dm_read = (t <= 12); dm_addr = 32'h40;
            @(negedge clk);
            compared++; if (mem_en !== (t inside {1, 4, 7, 10})) begin mismatched++; $display("FAIL b2b_mem_en t%0d: got %b", t, mem_en); end
            if (t inside {1, 4, 7, 10}) begin
                compared++; if (mem_addr !== ((t == 1 || t == 7) ? 32'h40 : 32'h104)) begin mismatched++; $display("FAIL b2b_order t%0d: got addr %h", t, mem_addr); end
            end
        end
        compared++; if (conflict_cnt !== 16'd9) begin mismatched++; $display("FAIL b2b_conflict: got %0d required 9", conflict_cnt); end
        compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL b2b_missing: got %0d outstanding required 0", sb.size()); end
    endtask

    task automatic test_store;
        settle;
        sb.push_back('{1'b1, base + 4, 32'h11112222});
        sb.push_back('{1'b1, base + 9, 32'hDEADBEEF});
        for (int t = 1; t <= 10; t++) begin
            next_cycle;
            dm_write = (t <= 4); dm_read = (t >= 6 && t <= 9); dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF;
            @(negedge clk);
            compared++; if (mem_en !== (t == 1 || t == 6)) begin mismatched++; $display("FAIL store_mem_en t%0d: got %b", t, mem_en); end
            if (t == 1) begin
                compared++;
                if (mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hDEADBEEF) begin
                    mismatched++; $display("FAIL store_issue: got we %b addr %h data %h required 1 80 deadbeef", mem_we, mem_addr, mem_wdata);
                end
            end
            if (t == 6) begin
                compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL load_we: got %b required 0", mem_we); end
            end
        end
        compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL store_missing: got %0d outstanding required 0", sb.size()); end
    endtask

    task automatic test_write_wins;
        settle;
        sb.push_back('{1'b1, base + 4, 32'hDEADBEEF});
        for (int t = 1; t <= 5; t++) begin
            next_cycle;
            dm_read = (t <= 4); dm_write = (t <= 4); dm_addr = 32'h90; dm_wdata = 32'hCAFEF00D;
            @(negedge clk);
            if (t == 1) begin
                compared++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin mismatched++; $display("FAIL write_wins: got en %b we %b required 1 1", mem_en, mem_we); end
            end
        end
        compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL write_wins_missing: got %0d outstanding required 0", sb.size()); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        sb.push_back('{1'b0, base + 6, 32'h2402000A});
        for (int t = 1; t <= 7; t++) begin
            next_cycle;
            rst = (t == 2); if_req = (t <= 6); if_addr = 32'h100;
            @(negedge clk);
            compared++; if (mem_en !== (t == 1 || t == 3)) begin mismatched++; $display("FAIL rmid_mem_en t%0d: got %b", t, mem_en); end
            if (t == 3) begin
                compared++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin mismatched++; $display("FAIL rmid_ready: got %b%b required 00", if_ready, dm_ready); end
                compared++; if (if_rdata !== 32'h0 || conflict_cnt !== 16'h0) begin mismatched++; $display("FAIL rmid_clear: got %h %h required 0 0", if_rdata, conflict_cnt); end
                compared++; if (mem_addr !== 32'h100) begin mismatched++; $display("FAIL rmid_reissue: got %h required 100", mem_addr); end
            end
        end
        compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL rmid_missing: got %0d outstanding required 0", sb.size()); end
    endtask

    task automatic test_lat1;
        settle;
        for (int t = 1; t <= 4; t++) begin
            next_cycle;
            l1_dm_read = (t <= 3); l1_dm_addr = 32'h44;
            l1_mem_rdata = (t == 2) ? 32'h5A5A0001 : 32'hBAD0BAD0;
            @(negedge clk);
            compared++; if (l1_mem_en !== (t == 1)) begin mismatched++; $display("FAIL lat1_mem_en t%0d: got %b", t, l1_mem_en); end
            compared++; if (l1_dm_ready !== (t == 3)) begin mismatched++; $display("FAIL lat1_ready t%0d: got %b required %b", t, l1_dm_ready, t == 3); end
            if (t == 3) begin
                compared++; if (l1_dm_rdata !== 32'h5A5A0001) begin mismatched++; $display("FAIL lat1_rdata: got %h required 5a5a0001", l1_dm_rdata); end
            end
        end
    endtask

    initial begin
        l1_if_req = 1'b0; l1_if_addr = '0; l1_dm_read = 1'b0; l1_dm_write = 1'b0;
        l1_dm_addr = '0; l1_dm_wdata = '0; l1_mem_rdata = '0;
        test_reset;
        test_if_only;
        test_tie;
        test_back_to_back;
        test_store;
        test_write_wins;
        test_reset_mid;
        test_lat1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
